// File: rtl/priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : priority_arbiter
//  Description : Registered N-way arbiter. Fixed priority (highest index wins)
//                or round-robin, with a valid/ready hold-until-accepted grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_arbiter #(
    parameter int N    = 8,
    parameter int MODE = 0,
    localparam int W   = (N > 2) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_gnt,
    output logic         out_multi
);

    localparam logic [0:0]   c_idle = 1'b0;
    localparam logic [0:0]   c_hold = 1'b1;
    localparam logic [W-1:0] c_last = W'(N - 1);

    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic         w_load;
    logic         w_any;
    logic         w_multi;
    logic [W-1:0] w_search_ptr;
    logic [W-1:0] w_win;

    logic [W-1:0] r_idx;
    logic [N-1:0] r_gnt;
    logic         r_multi;

    assign w_any   = |req;
    assign w_multi = |(req & (req - N'(1)));

    // Search start point: constant top index in fixed mode, live pointer in
    // round-robin mode (already advanced past a grant accepted this cycle).
    generate
        if (MODE == 1) begin : g_rr
            logic [W-1:0] r_ptr;
            logic [W-1:0] w_ptr_dec;
            logic         w_accept;

            assign w_accept     = (r_state == c_hold) && out_ready;
            assign w_ptr_dec    = (r_idx == '0) ? c_last : (r_idx - W'(1));
            assign w_search_ptr = w_accept ? w_ptr_dec : r_ptr;

            // Pointer moves to one below the served index on each acceptance.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ptr <= c_last;
                end else if (w_accept) begin
                    r_ptr <= w_ptr_dec;
                end
            end
        end else begin : g_fixed
            assign w_search_ptr = c_last;
        end
    endgenerate

    // Scan downward from the search pointer with wrap; first set bit wins.
    always_comb begin
        logic         v_found;
        logic [W-1:0] v_pos;
        v_found = 1'b0;
        v_pos   = '0;
        w_win   = '0;
        for (int j = 0; j < N; j++) begin
            if (j <= int'(w_search_ptr)) begin
                v_pos = W'(int'(w_search_ptr) - j);
            end else begin
                v_pos = W'(int'(w_search_ptr) + N - j);
            end
            if (!v_found && req[v_pos]) begin
                v_found = 1'b1;
                w_win   = v_pos;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and load decision; a grant is replaced only when idle or
    // when the current one is being accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_hold;
                end
            end
            c_hold: begin
                if (out_ready) begin
                    if (w_any) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = c_idle;
                    end
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // Grant registers: winner and multi flag captured from the same sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_gnt   <= '0;
            r_multi <= 1'b0;
        end else if (w_load) begin
            r_idx   <= w_win;
            r_gnt   <= N'(1) << w_win;
            r_multi <= w_multi;
        end else if (w_state_nxt == c_idle) begin
            r_gnt   <= '0;
        end
    end

    assign out_valid = (r_state == c_hold);
    assign out_idx   = r_idx;
    assign out_gnt   = r_gnt;
    assign out_multi = r_multi;

endmodule
`default_nettype wire

// File: tb/tb_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_priority_arbiter
//  Description : Bench for priority_arbiter, N=8, both modes side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_arbiter;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         out_ready;

    logic [1:0]   dv;
    logic [2:0]   di [2];
    logic [N-1:0] dg [2];
    logic [1:0]   dm;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    // Reference state: one set per mode.
    bit m_valid [2];
    int m_idx   [2];
    bit m_multi [2];
    int m_ptr   [2];

    priority_arbiter #(.N(N), .MODE(0)) u_fixed (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .out_valid(dv[0]), .out_idx(di[0]), .out_gnt(dg[0]), .out_multi(dm[0])
    );

    priority_arbiter #(.N(N), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .out_valid(dv[1]), .out_idx(di[1]), .out_gnt(dg[1]), .out_multi(dm[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First requester met when walking p, p-1, ..., 0, N-1, ..., p+1.
    function automatic int winner(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++) begin
            int pos;
            pos = (p - j + N) % N;
            if (r[pos]) return pos;
        end
        return -1;
    endfunction

    // Reference model, advanced on every rising edge.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_valid[m] = 0;
                m_idx[m]   = 0;
                m_multi[m] = 0;
                m_ptr[m]   = N - 1;
            end else begin
                if (m == 1 && m_valid[m] && out_ready)
                    m_ptr[m] = (m_idx[m] + N - 1) % N;
                if (!m_valid[m] || out_ready) begin
                    if (req != 0) begin
                        m_idx[m]   = winner(req, (m == 1) ? m_ptr[m] : N - 1);
                        m_multi[m] = ($countones(req) > 1);
                        m_valid[m] = 1;
                    end else begin
                        m_valid[m] = 0;
                    end
                end
            end
        end
    end

    // Compare DUT against model on every falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int m = 0; m < 2; m++) begin
                logic [N-1:0] eg;
                eg = m_valid[m] ? (N'(1) << m_idx[m]) : '0;
                chk($sformatf("m%0d valid", m), 32'(dv[m]), 32'(m_valid[m]));
                chk($sformatf("m%0d gnt", m), 32'(dg[m]), 32'(eg));
                if (m_valid[m]) begin
                    chk($sformatf("m%0d idx", m), 32'(di[m]), 32'(m_idx[m]));
                    chk($sformatf("m%0d multi", m), 32'(dm[m]), 32'(m_multi[m]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int seq [9];
        logic [N-1:0] tbl_req [8];
        bit tbl_rdy [8];
        seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        tbl_req = '{8'h5A, 8'h3C, 8'h00, 8'h81, 8'h42, 8'hFF, 8'h01, 8'h24};
        tbl_rdy = '{1, 0, 1, 1, 0, 1, 1, 1};

        rst_n = 1'b0; req = '0; out_ready = 1'b0;
        tick();
        started = 1;
        tick();
        for (int m = 0; m < 2; m++) begin
            chk("reset valid", 32'(dv[m]), 0);
            chk("reset idx",   32'(di[m]), 0);
            chk("reset gnt",   32'(dg[m]), 0);
            chk("reset multi", 32'(dm[m]), 0);
        end

        // Idle with no requests, then a single request at index 0.
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle valid", 32'(dv[0]), 0);
            chk("idle gnt",   32'(dg[0]), 0);
        end
        req = 8'h01;
        tick();
        chk("single valid", 32'(dv[0]), 1);
        chk("single idx",   32'(di[0]), 0);
        chk("single multi", 32'(dm[0]), 0);
        out_ready = 1'b1; req = '0;
        tick();
        chk("drain valid", 32'(dv[0]), 0);
        chk("drain gnt",   32'(dg[0]), 0);

        // Fixed priority picks highest index.
        req = 8'b0010_0110;
        tick();
        chk("fixed valid", 32'(dv[0]), 1);
        chk("fixed idx",   32'(di[0]), 5);
        chk("fixed gnt",   32'(dg[0]), 32'h20);
        chk("fixed multi", 32'(dm[0]), 1);
        req = '0;
        tick();

        // Round-robin rotation with all requesting.
        do_reset();
        req = 8'hFF; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("rr seq%0d", k), 32'(di[1]), 32'(seq[k]));
            chk("fixed under ff", 32'(di[0]), 7);
        end
        req = '0;
        tick();

        // Two requesters with ready toggling.
        do_reset();
        req = 8'h81; out_ready = 1'b1;
        tick(); chk("tog load",  32'(di[1]), 7);
        out_ready = 1'b0;
        tick(); chk("tog held",  32'(di[1]), 7);
        out_ready = 1'b1;
        tick(); chk("tog next0", 32'(di[1]), 0);
        tick(); chk("tog next7", 32'(di[1]), 7);

        // Hold stability while req changes.
        req = '0; out_ready = 1'b1;
        tick(); chk("hold pre idle", 32'(dv[1]), 0);
        req = 8'h08; out_ready = 1'b0;
        tick();
        chk("hold idx3 f", 32'(di[0]), 3);
        chk("hold idx3 r", 32'(di[1]), 3);
        req = 8'h80;
        tick();
        tick();
        chk("hold stable f", 32'(di[0]), 3);
        chk("hold stable r", 32'(di[1]), 3);
        chk("hold gnt r",    32'(dg[1]), 32'h08);
        out_ready = 1'b1;
        tick();
        chk("hold next f", 32'(di[0]), 7);
        chk("hold next r", 32'(di[1]), 7);

        // Reset while holding discards the grant.
        req = '0;
        tick();
        req = 8'h10; out_ready = 1'b0;
        tick(); chk("rsthold idx4", 32'(di[1]), 4);
        rst_n = 1'b0; req = 8'hFF;
        tick();
        chk("rsthold valid r", 32'(dv[1]), 0);
        chk("rsthold valid f", 32'(dv[0]), 0);
        rst_n = 1'b1;
        tick();
        chk("post rst valid", 32'(dv[1]), 1);
        chk("post rst idx",   32'(di[1]), 7);

        // Mixed vectors, checked by the model.
        for (int k = 0; k < 8; k++) begin
            req = tbl_req[k]; out_ready = tbl_rdy[k];
            tick();
        end
        req = '0; out_ready = 1'b1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
